// File: rtl/lsu_mem_port.sv
// Load/store port in front of a byte-addressable data RAM: one request at a time,
// a single-cycle RAM access, then a registered response held until it is consumed.
module lsu_mem_port #(
    parameter int MEM_BYTES = 256,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic          req_byte,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic [1:0]    mem_be,
    output logic          mem_we,
    input  logic [15:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so the comparison stays correct for any MEM_BYTES up to 2**AW.
    localparam logic [AW:0] BYTE_LIMIT = MEM_BYTES[AW:0];
    localparam logic [AW:0] WORD_LIMIT = BYTE_LIMIT - 1'b1;

    state_t        state_q,  state_d;
    logic          write_q,  write_d;
    logic          byte_q,   byte_d;
    logic          signed_q, signed_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic [15:0]   wdata_q,  wdata_d;
    logic [15:0]   rdata_q,  rdata_d;
    logic          err_q,    err_d;

    logic [AW:0]   req_addr_ext;
    logic          range_err;

    assign req_addr_ext = {1'b0, req_addr};
    assign range_err    = req_byte ? (req_addr_ext >= BYTE_LIMIT)
                                   : (req_addr_ext >= WORD_LIMIT);

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    byte_d   = req_byte;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 16'h0000;
                    err_d    = range_err;
                    state_d  = range_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (write_q) begin
                    rdata_d = 16'h0000;
                end else if (byte_q) begin
                    rdata_d = {{8{signed_q & mem_rdata[7]}}, mem_rdata[7:0]};
                end else begin
                    rdata_d = mem_rdata;
                end
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Write enable is decoded straight from the state so reset kills it without waiting for an edge.
    assign mem_we    = (state_q == ACCESS) && write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = byte_q ? 2'b01 : 2'b11;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 256-byte big-endian RAM model attached.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] ram [0:255];

    lsu_mem_port #(.MEM_BYTES(256), .AW(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: word mode is big-endian {byte[A], byte[A+1]}; byte mode puts byte[A] on [7:0].
    logic [7:0] ram_a;
    logic [7:0] ram_a1;
    always_comb begin
        ram_a  = mem_addr[7:0];
        ram_a1 = ram_a + 8'd1;
        if (mem_be == 2'b01) mem_rdata = {8'h00, ram[ram_a]};
        else                 mem_rdata = {ram[ram_a], ram[ram_a1]};
    end

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_be == 2'b01) begin
                ram[ram_a] <= mem_wdata[7:0];
            end else begin
                ram[ram_a]  <= mem_wdata[15:8];
                ram[ram_a1] <= mem_wdata[7:0];
            end
        end
    end

    // Issues one request and consumes its response; lat = cycles from accept to rsp_valid.
    task automatic do_req(input logic w, input logic b, input logic s,
                          input logic [15:0] a, input logic [15:0] wd,
                          output logic [15:0] rd, output logic er,
                          output int lat, output int we_cnt, output logic [1:0] be_acc);
        @(negedge clk);
        req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1; we_cnt = 0; be_acc = mem_be;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            if (mem_we === 1'b1) we_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (mem_we === 1'b1) we_cnt++;
        if (lat >= 10) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout addr=%h: rsp_valid never rose within 10 cycles", a);
        end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", busy); end
        n_cmp++; if (mem_be !== 2'b11) begin n_fail++; $display("FAIL rst_mem_be got=%b want=11", mem_be); end
        n_cmp++; if (rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rsp_rdata got=%h want=0000", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got=%b want=0", rsp_err); end
        n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_addr got=%h want=0000", mem_addr); end
        @(negedge clk);
        reset = 1'b0;
        $display("reset: req_ready=%b busy=%b mem_be=%b", req_ready, busy, mem_be);
    endtask

    task automatic test_word_store_load();
        logic [15:0] rd; logic er; int lat, wc; logic [1:0] be;
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, rd, er, lat, wc, be);
        $display("store w @0010 <= 1234: err=%b lat=%0d we_cycles=%0d", er, lat, wc);
        n_cmp++; if (wc !== 1) begin n_fail++; $display("FAIL st_we_cycles got=%0d want=1", wc); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL st_latency got=%0d want=2", lat); end
        n_cmp++; if (rd !== 16'h0000 || er !== 1'b0) begin n_fail++; $display("FAIL st_rsp got=%h/%b want=0000/0", rd, er); end
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, er, lat, wc, be);
        $display("load w @0010: rdata=%h err=%b", rd, er);
        n_cmp++; if (rd !== 16'h1234) begin n_fail++; $display("FAIL ld_word got=%h want=1234", rd); end
        n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL ld_word_we got=%0d want=0", wc); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, rd, er, lat, wc, be);
        $display("load b @0010: rdata=%h", rd);
        n_cmp++; if (rd !== 16'h0012) begin n_fail++; $display("FAIL ld_byte10 got=%h want=0012", rd); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, rd, er, lat, wc, be);
        $display("load b @0011: rdata=%h", rd);
        n_cmp++; if (rd !== 16'h0034) begin n_fail++; $display("FAIL ld_byte11 got=%h want=0034", rd); end
    endtask

    task automatic test_byte_store();
        logic [15:0] rd; logic er; int lat, wc; logic [1:0] be;
        do_req(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1357, rd, er, lat, wc, be);
        do_req(1'b1, 1'b1, 1'b0, 16'h0020, 16'hAA80, rd, er, lat, wc, be);
        $display("store b @0020 <= AA80: be=%b we_cycles=%0d", be, wc);
        n_cmp++; if (be !== 2'b01) begin n_fail++; $display("FAIL stb_be got=%b want=01", be); end
        n_cmp++; if (wc !== 1) begin n_fail++; $display("FAIL stb_we_cycles got=%0d want=1", wc); end
        do_req(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, rd, er, lat, wc, be);
        $display("load sb @0020: rdata=%h", rd);
        n_cmp++; if (rd !== 16'hFF80) begin n_fail++; $display("FAIL ld_sbyte got=%h want=FF80", rd); end
        do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, rd, er, lat, wc, be);
        $display("load ub @0020: rdata=%h", rd);
        n_cmp++; if (rd !== 16'h0080) begin n_fail++; $display("FAIL ld_ubyte got=%h want=0080", rd); end
        do_req(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, rd, er, lat, wc, be);
        $display("load sb @0021: rdata=%h", rd);
        n_cmp++; if (rd !== 16'h0057) begin n_fail++; $display("FAIL ld_neighbour got=%h want=0057", rd); end
    endtask

    task automatic test_range_errors();
        logic [15:0] rd; logic er; int lat, wc; logic [1:0] be;
        do_req(1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, rd, er, lat, wc, be);
        $display("load w @00FF: err=%b rdata=%h lat=%0d", er, rd, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_ldw_flag got=%b want=1", er); end
        n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL err_ldw_rdata got=%h want=0000", rd); end
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL err_ldw_latency got=%0d want=1", lat); end
        do_req(1'b1, 1'b0, 1'b0, 16'h00FF, 16'hDEAD, rd, er, lat, wc, be);
        $display("store w @00FF: err=%b we_cycles=%0d", er, wc);
        n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_stw_flag got=%b want=1", er); end
        n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL err_stw_we got=%0d want=0", wc); end
        do_req(1'b0, 1'b1, 1'b0, 16'h00FF, 16'h0000, rd, er, lat, wc, be);
        $display("load b @00FF: err=%b lat=%0d", er, lat);
        n_cmp++; if (er !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL ok_ldb_ff got=%b/%0d want=0/2", er, lat); end
        do_req(1'b1, 1'b1, 1'b0, 16'h0100, 16'h00AB, rd, er, lat, wc, be);
        $display("store b @0100: err=%b we_cycles=%0d", er, wc);
        n_cmp++; if (er !== 1'b1 || wc !== 0) begin n_fail++; $display("FAIL err_stb_100 got=%b/%0d want=1/0", er, wc); end
    endtask

    task automatic test_backpressure();
        logic [15:0] rd; logic er; int lat, wc; logic [1:0] be;
        do_req(1'b1, 1'b0, 1'b0, 16'h0030, 16'hBEEF, rd, er, lat, wc, be);
        @(negedge clk);
        req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h0030;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        // Pending follow-up request: word load @0010, held valid through the stall.
        req_addr = 16'h0010;
        @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid got=%b want=1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            $display("stall %0d: rsp_valid=%b rdata=%h req_ready=%b", i, rsp_valid, rsp_rdata, req_ready);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hBEEF || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d got=%b/%h/%b want=1/BEEF/0", i, rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b/%b want=1/0", req_ready, rsp_valid); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || mem_addr !== 16'h0010) begin n_fail++; $display("FAIL bp_accept got=%b/%h want=1/0010", busy, mem_addr); end
        @(posedge clk);
        #1;
        $display("pending load @0010: rsp_valid=%b rdata=%h", rsp_valid, rsp_rdata);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234) begin n_fail++; $display("FAIL bp_pending got=%b/%h want=1/1234", rsp_valid, rsp_rdata); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] rd; logic er; int lat, wc; logic [1:0] be;
        do_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'h1111, rd, er, lat, wc, be);
        @(negedge clk);
        req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0040; req_wdata = 16'h5555;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rma_we_before got=%b want=1", mem_we); end
        #2;
        reset = 1'b1;
        #1;
        $display("reset mid-access: mem_we=%b busy=%b rsp_valid=%b", mem_we, busy, rsp_valid);
        n_cmp++; if (mem_we !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rma_async got=%b/%b/%b want=0/0/0", mem_we, busy, rsp_valid); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rma_no_rsp got=%b want=0", rsp_valid); end
        do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, rd, er, lat, wc, be);
        $display("load w @0040 after dropped store: rdata=%h", rd);
        n_cmp++; if (rd !== 16'h1111) begin n_fail++; $display("FAIL rma_contents got=%h want=1111", rd); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        test_reset();
        test_word_store_load();
        test_byte_store();
        test_range_errors();
        test_backpressure();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
